// File: rtl/sram_to_sd_saver_if.sv
// SRAM read port plus the write side of the SD access engine.
// master = the saver, slave = the SRAM/SD engine side.
interface sram_to_sd_saver_if;
    logic [18:0] sram_addr;
    logic [7:0]  sram_data;
    logic        sd_initialized;
    logic        sd_busy;
    logic        sd_wr_start;
    logic [31:0] sd_sector_addr;
    logic        sd_data_req_n;
    logic [7:0]  sd_data_out;

    modport master (
        output sram_addr,
        input  sram_data,
        input  sd_initialized,
        input  sd_busy,
        output sd_wr_start,
        output sd_sector_addr,
        input  sd_data_req_n,
        output sd_data_out
    );

    modport slave (
        input  sram_addr,
        output sram_data,
        output sd_initialized,
        output sd_busy,
        input  sd_wr_start,
        input  sd_sector_addr,
        output sd_data_req_n,
        input  sd_data_out
    );
endinterface

// File: rtl/sram_to_sd_saver.sv
// sram_to_sd_saver: copies an image from SRAM back to an SD card slot,
// one 512-byte sector at a time. Counterpart of the ROM loader and uses the
// same slot addressing: sector = {zero pad, slot, sector index}.
// Optional feature macro: SAVER_CHECKSUM_EN (8-bit running sum of bytes sent).
module sram_to_sd_saver #(
    parameter int          SECTOR_BITS = 4,
    parameter int          SLOT_BITS   = 16,
    parameter logic [18:0] SRAM_BASE   = 19'h00000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 doSaveRom,
    input  logic [SLOT_BITS-1:0] selectedSlot,
    output logic [SLOT_BITS-1:0] currentSlot,
    output logic                 saving,
    output logic                 save_done,
    output logic                 save_error,
    output logic [7:0]           checksum,
    sram_to_sd_saver_if.master   bus
);

    localparam int PAD_BITS = 32 - SLOT_BITS - SECTOR_BITS;
    // One past the last sector: reaching it means the image is complete.
    localparam logic [SECTOR_BITS:0] SEC_END = {1'b1, {SECTOR_BITS{1'b0}}};

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_FETCH,
        S_START,
        S_WAIT_REQ,
        S_WAIT_REL,
        S_WAIT_IDLE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t               state;
    logic                 fetch_ph;     // 0: drive address, 1: capture data
    logic [SECTOR_BITS:0] sector_idx;
    logic [9:0]           byte_idx;
    logic [9:0]           byte_nxt;
    logic [18:0]          fetch_addr;

    assign byte_nxt   = byte_idx + 10'd1;
    assign fetch_addr = SRAM_BASE + 19'({sector_idx, byte_idx[8:0]});

    assign bus.sd_sector_addr = {{PAD_BITS{1'b0}}, currentSlot, sector_idx[SECTOR_BITS-1:0]};

    // Save sequencer: arming on doSaveRom, SRAM prefetch, per-byte handshake
    // with the SD engine, and per-sector wait for the engine to go idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            fetch_ph        <= 1'b0;
            sector_idx      <= '0;
            byte_idx        <= '0;
            currentSlot     <= '0;
            saving          <= 1'b0;
            save_done       <= 1'b0;
            save_error      <= 1'b0;
            bus.sd_wr_start <= 1'b0;
            bus.sd_data_out <= 8'hFF;
            bus.sram_addr   <= SRAM_BASE;
        end else begin
            save_done       <= 1'b0;
            bus.sd_wr_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (doSaveRom)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    // Start on the falling edge of the request.
                    if (!doSaveRom) begin
                        currentSlot <= selectedSlot;
                        save_error  <= 1'b0;
                        saving      <= 1'b1;
                        sector_idx  <= '0;
                        byte_idx    <= '0;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!bus.sd_initialized) begin
                        save_error <= 1'b1;
                        saving     <= 1'b0;
                        state      <= S_ERROR;
                    end else if (!bus.sd_busy) begin
                        fetch_ph <= 1'b0;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Prefetch so sd_data_out is stable before req_n falls.
                    if (!fetch_ph) begin
                        bus.sram_addr <= fetch_addr;
                        fetch_ph      <= 1'b1;
                    end else begin
                        bus.sd_data_out <= bus.sram_data;
                        fetch_ph        <= 1'b0;
                        state           <= (byte_idx == 10'd0) ? S_START : S_WAIT_REQ;
                    end
                end
                S_START: begin
                    if (sector_idx == SEC_END) begin
                        save_done <= 1'b1;
                        saving    <= 1'b0;
                        state     <= S_DONE;
                    end else if (!bus.sd_busy) begin
                        bus.sd_wr_start <= 1'b1;
                        state           <= S_WAIT_REQ;
                    end
                end
                S_WAIT_REQ: begin
                    if (!bus.sd_data_req_n) begin
                        state <= S_WAIT_REL;
                    end else if (!bus.sd_initialized) begin
                        save_error <= 1'b1;
                        saving     <= 1'b0;
                        state      <= S_ERROR;
                    end
                end
                S_WAIT_REL: begin
                    // A whole low period of req_n is one byte.
                    if (bus.sd_data_req_n) begin
                        if (byte_nxt == 10'd512) begin
                            byte_idx   <= '0;
                            sector_idx <= sector_idx + 1'b1;
                            state      <= S_WAIT_IDLE;
                        end else begin
                            byte_idx <= byte_nxt;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    // Let the engine finish CRC and card busy for the sector.
                    if (!bus.sd_busy) begin
                        fetch_ph <= 1'b0;
                        state    <= S_FETCH;
                    end else if (!bus.sd_initialized) begin
                        save_error <= 1'b1;
                        saving     <= 1'b0;
                        state      <= S_ERROR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERROR: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SAVER_CHECKSUM_EN
    logic       start_evt;
    logic       byte_evt;
    logic [7:0] csum;

    assign start_evt = (state == S_ARMED) && !doSaveRom;
    assign byte_evt  = (state == S_WAIT_REL) && bus.sd_data_req_n;

    // Running wrap-around sum of bytes the engine has consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            csum <= 8'h00;
        else if (start_evt)
            csum <= 8'h00;
        else if (byte_evt)
            csum <= csum + bus.sd_data_out;
    end

    assign checksum = csum;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_sram_to_sd_saver.sv
// Directed bench for sram_to_sd_saver: two instances (1 sector bit at base 0,
// 4 sector bits at base 19'h10000) share one behavioural SD engine model.
module tb_sram_to_sd_saver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        do_save0, do_save1;
    logic [15:0] sel_slot;
    logic [15:0] cur_slot0, cur_slot1;
    logic        saving0, saving1, done0, done1, err0, err1;
    logic [7:0]  csum0, csum1;
    logic        eng_init, eng_busy, eng_req_n;
    int          sel;

    sram_to_sd_saver_if if0();
    sram_to_sd_saver_if if1();

    // SRAM image: byte at offset i holds i[7:0]; both bases have low byte 0.
    assign if0.sram_data      = if0.sram_addr[7:0];
    assign if1.sram_data      = if1.sram_addr[7:0];
    assign if0.sd_initialized = eng_init;
    assign if1.sd_initialized = eng_init;
    assign if0.sd_busy        = eng_busy;
    assign if1.sd_busy        = eng_busy;
    assign if0.sd_data_req_n  = eng_req_n;
    assign if1.sd_data_req_n  = eng_req_n;

    sram_to_sd_saver #(.SECTOR_BITS(1), .SLOT_BITS(16), .SRAM_BASE(19'h00000)) dut0 (
        .clk(clk), .rst_n(rst_n), .doSaveRom(do_save0), .selectedSlot(sel_slot),
        .currentSlot(cur_slot0), .saving(saving0), .save_done(done0),
        .save_error(err0), .checksum(csum0), .bus(if0.master));

    sram_to_sd_saver #(.SECTOR_BITS(4), .SLOT_BITS(16), .SRAM_BASE(19'h10000)) dut1 (
        .clk(clk), .rst_n(rst_n), .doSaveRom(do_save1), .selectedSlot(sel_slot),
        .currentSlot(cur_slot1), .saving(saving1), .save_done(done1),
        .save_error(err1), .checksum(csum1), .bus(if1.master));

    // view of whichever instance the engine is serving
    logic        m_wr_start, m_saving, m_done, m_err;
    logic [7:0]  m_dout, m_csum;
    logic [31:0] m_sec;
    logic [18:0] m_addr;
    logic [15:0] m_slot;
    always_comb begin
        if (sel == 1) begin
            m_wr_start = if1.sd_wr_start; m_dout = if1.sd_data_out;
            m_sec = if1.sd_sector_addr;   m_addr = if1.sram_addr;
            m_saving = saving1; m_done = done1; m_err = err1;
            m_csum = csum1;     m_slot = cur_slot1;
        end else begin
            m_wr_start = if0.sd_wr_start; m_dout = if0.sd_data_out;
            m_sec = if0.sd_sector_addr;   m_addr = if0.sram_addr;
            m_saving = saving0; m_done = done0; m_err = err0;
            m_csum = csum0;     m_slot = cur_slot0;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // engine model results
    int          e_bytes, e_bad, e_starts, e_extra, e_done, e_not_saving;
    int          e_first_start_cyc, e_err_cyc, e_timeout;
    logic [7:0]  e_sum;
    logic [18:0] e_first_addr, e_last_addr;
    logic [31:0] e_sec [16];

    function automatic logic [7:0] exp_csum(input logic [7:0] s);
`ifdef SAVER_CHECKSUM_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    task automatic start_save(input int which, input logic [15:0] slot);
        sel      = which;
        sel_slot = slot;
        @(negedge clk);
        if (which == 1) do_save1 = 1'b1; else do_save0 = 1'b1;
        repeat (2) @(negedge clk);
        do_save0 = 1'b0;
        do_save1 = 1'b0;
    endtask

    // Lower req_n for the next byte (or drop sd_initialized at drop_at).
    task automatic present_byte(input int drop_at, input int low_len, inout int st, inout int cnt);
        if (e_bytes == drop_at) begin
            eng_init = 1'b0;
            st = 9;
        end else begin
            eng_req_n = 1'b0;
            if (m_dout !== 8'(e_bytes)) e_bad++;
            if (e_bytes == 0) e_first_addr = m_addr;
            e_last_addr = m_addr;
            st  = 1;
            cnt = low_len;
        end
    endtask

    // Behavioural SD write engine, driven on negedges. Waits 3 cycles after
    // each release (WAIT_REL + 2 FETCH) before asking for the next byte.
    task automatic engine(input int low_len, input int stop_at, input int drop_at);
        int st, cnt, sec_bytes;
        logic finished;
        st = 0; cnt = 0; sec_bytes = 0; finished = 1'b0;
        e_bytes = 0; e_bad = 0; e_starts = 0; e_extra = 0; e_done = 0;
        e_not_saving = 0; e_first_start_cyc = -1; e_err_cyc = -1; e_timeout = 0;
        e_sum = 8'h00; e_first_addr = '0; e_last_addr = '0;
        for (int i = 0; i < 16; i++) e_sec[i] = '0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            if (m_done) begin e_done++; finished = 1'b1; end
            if (m_err) begin e_err_cyc = cyc; finished = 1'b1; end
            if (m_wr_start && st != 0) e_extra++;
            case (st)
                0: if (m_wr_start) begin
                    if (e_starts < 16) e_sec[e_starts] = m_sec;
                    if (e_starts == 0) e_first_start_cyc = cyc;
                    if (!m_saving) e_not_saving++;
                    e_starts++;
                    eng_busy  = 1'b1;
                    sec_bytes = 0;
                    present_byte(drop_at, low_len, st, cnt);
                end
                1: begin
                    cnt--;
                    if (cnt == 0) begin
                        eng_req_n = 1'b1;
                        e_sum = e_sum + 8'(e_bytes);
                        e_bytes++;
                        sec_bytes++;
                        if (e_bytes == stop_at) finished = 1'b1;
                        else if (sec_bytes == 512) begin st = 3; cnt = 5; end
                        else begin st = 2; cnt = 3; end
                    end
                end
                2: begin
                    cnt--;
                    if (cnt == 0) present_byte(drop_at, low_len, st, cnt);
                end
                3: begin
                    cnt--;
                    if (cnt == 0) begin eng_busy = 1'b0; st = 0; end
                end
                default: ;
            endcase
            if (finished) break;
        end
        if (!finished) e_timeout = 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        eng_busy = 1'b0; eng_req_n = 1'b1; eng_init = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; do_save0 = 1'b0; do_save1 = 1'b0; sel = 0; sel_slot = '0;
        eng_init = 1'b1; eng_busy = 1'b0; eng_req_n = 1'b1;

        // ---- reset values
        repeat (3) @(negedge clk);
        chk("rst_saving",   {31'b0, saving0}, 32'd0);
        chk("rst_done",     {31'b0, done0}, 32'd0);
        chk("rst_error",    {31'b0, err0}, 32'd0);
        chk("rst_slot",     {16'b0, cur_slot0}, 32'd0);
        chk("rst_wr_start", {31'b0, if0.sd_wr_start}, 32'd0);
        chk("rst_dout",     {24'b0, if0.sd_data_out}, 32'h0000_00FF);
        chk("rst_addr0",    {13'b0, if0.sram_addr}, 32'h0);
        chk("rst_addr1",    {13'b0, if1.sram_addr}, 32'h0001_0000);
        chk("rst_secaddr",  if0.sd_sector_addr, 32'h0);
        chk("rst_csum",     {24'b0, csum0}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- run A: slot 3, 1 sector bit, 1-cycle req pulses
        start_save(0, 16'h0003);
        engine(1, -1, -1);
        chk("A_timeout",   e_timeout, 0);
        chk("A_latency",   e_first_start_cyc, 4);
        chk("A_starts",    e_starts, 2);
        chk("A_sec0",      e_sec[0], 32'h0000_0006);   // {slot 3, sector 0}
        chk("A_sec1",      e_sec[1], 32'h0000_0007);
        chk("A_bytes",     e_bytes, 1024);
        chk("A_bad_bytes", e_bad, 0);
        chk("A_first_adr", {13'b0, e_first_addr}, 32'h0);
        chk("A_last_adr",  {13'b0, e_last_addr}, 32'h3FF);
        chk("A_done",      e_done, 1);
        chk("A_extra_wr",  e_extra, 0);
        chk("A_not_saving", e_not_saving, 0);
        chk("A_saving_end", {31'b0, saving0}, 32'd0);
        chk("A_error",     {31'b0, err0}, 32'd0);
        chk("A_slot",      {16'b0, cur_slot0}, 32'h3);
        chk("A_csum",      {24'b0, m_csum}, {24'b0, exp_csum(e_sum)});
        @(negedge clk);
        chk("A_done_pulse", {31'b0, done0}, 32'd0);

        // ---- run B: slot A5, req_n held low 5 cycles per byte
        start_save(0, 16'h00A5);
        engine(5, -1, -1);
        chk("B_timeout",   e_timeout, 0);
        chk("B_sec0",      e_sec[0], 32'h0000_014A);
        chk("B_sec1",      e_sec[1], 32'h0000_014B);
        chk("B_bytes",     e_bytes, 1024);
        chk("B_bad_bytes", e_bad, 0);
        chk("B_done",      e_done, 1);
        chk("B_extra_wr",  e_extra, 0);
        chk("B_slot",      {16'b0, m_slot}, 32'h00A5);

        // ---- SD not initialised at start
        eng_init = 1'b0;
        start_save(0, 16'h0003);
        engine(1, -1, -1);
        chk("I_timeout",  e_timeout, 0);
        chk("I_err_lat",  {31'b0, (e_err_cyc >= 0 && e_err_cyc <= 2)}, 32'd1);
        chk("I_starts",   e_starts, 0);
        chk("I_done",     e_done, 0);
        chk("I_saving",   {31'b0, saving0}, 32'd0);
        eng_init = 1'b1;

        // ---- sd_initialized dropped at byte 100 of sector 0
        start_save(0, 16'h0003);
        engine(1, -1, 100);
        chk("D_timeout",  e_timeout, 0);
        chk("D_error",    {31'b0, err0}, 32'd1);
        chk("D_saving",   {31'b0, saving0}, 32'd0);
        chk("D_done",     e_done, 0);
        chk("D_bytes",    e_bytes, 100);
        chk("D_csum",     {24'b0, csum0}, {24'b0, exp_csum(8'h56)});   // sum 0..99
        eng_init = 1'b1; eng_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("D_err_sticky", {31'b0, err0}, 32'd1);

        // ---- restart clears error; async reset mid-sector
        start_save(0, 16'h0003);
        engine(1, 50, -1);
        chk("R_timeout",  e_timeout, 0);
        chk("R_err_clr",  {31'b0, err0}, 32'd0);
        chk("R_saving",   {31'b0, saving0}, 32'd1);
        chk("R_bad",      e_bad, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("R_rst_saving", {31'b0, saving0}, 32'd0);
        chk("R_rst_wr",     {31'b0, if0.sd_wr_start}, 32'd0);
        chk("R_rst_dout",   {24'b0, if0.sd_data_out}, 32'h0000_00FF);
        chk("R_rst_addr",   {13'b0, if0.sram_addr}, 32'h0);
        chk("R_rst_slot",   {16'b0, cur_slot0}, 32'h0);
        chk("R_rst_csum",   {24'b0, csum0}, 32'h0);
        eng_busy = 1'b0; eng_req_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_save(0, 16'h0003);
        engine(1, 3, -1);
        chk("R2_timeout", e_timeout, 0);
        chk("R2_sec0",    e_sec[0], 32'h0000_0006);
        chk("R2_first",   {13'b0, e_first_addr}, 32'h0);
        chk("R2_bad",     e_bad, 0);
        pulse_reset();

        // ---- 16-sector image at SRAM_BASE 19'h10000
        start_save(1, 16'h0001);
        engine(1, -1, -1);
        chk("W_timeout",   e_timeout, 0);
        chk("W_starts",    e_starts, 16);
        chk("W_sec0",      e_sec[0], 32'h0000_0010);
        chk("W_sec15",     e_sec[15], 32'h0000_001F);
        chk("W_bytes",     e_bytes, 8192);
        chk("W_bad",       e_bad, 0);
        chk("W_first_adr", {13'b0, e_first_addr}, 32'h0001_0000);
        chk("W_last_adr",  {13'b0, e_last_addr}, 32'h0001_1FFF);
        chk("W_done",      e_done, 1);
        chk("W_csum",      {24'b0, m_csum}, {24'b0, exp_csum(e_sum)});
        chk("W_dut0_idle", {31'b0, saving0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
